mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Single-outstanding request/response bridge between a requester and a word
// memory with a registered (one-cycle) read port. A request is accepted in
// IDLE, checked against MEM_DEPTH, and then turned into one write cycle, a
// read plus a read-wait cycle, or an immediate error response. The response
// is held in RESP until the requester takes it.
//
// Parameters
//   MEM_DEPTH   number of valid memory words; addresses >= MEM_DEPTH are
//               rejected with rsp_err
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-high reset
//   req_valid   requester has a transaction
//   req_write   1 = write, 0 = read (sampled with req_valid)
//   req_addr    word address
//   req_wdata   write data
//   req_ready   controller can accept a request (IDLE only)
//   rsp_valid   response available (RESP only)
//   rsp_ready   requester accepts the response
//   rsp_rdata   read data; 0 for writes and errors
//   rsp_err     request rejected, address out of range
//   mem_addr    address to memory (last accepted address)
//   mem_wdata   write data to memory (last accepted data)
//   mem_we      memory write enable, high only in WRITE
//   mem_rdata   registered memory read data, valid the cycle after a read
//               address is presented
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned MEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
        READ_WAIT = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic addr_oor;

    assign accept = req_valid && req_ready;

    // Compare in 32 bits so that MEM_DEPTH = 65536 is representable and
    // 0xFFFF never wraps back into range.
    assign addr_oor = ({16'h0000, req_addr} >= MEM_DEPTH);

    // State register. mem_we is decoded from the state, so an asynchronous
    // reset during WRITE drops the write strobe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs. The direction of an accepted
    // request is carried forward by the state itself (WRITE vs READ).
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (addr_oor) begin
                        state_next = RESP;
                    end else if (req_write) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                state_next = RESP;
            end
            READ: begin
                state_next = READ_WAIT;
            end
            READ_WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch and response registers.
    // mem_addr/mem_wdata are the latched request itself, so they hold their
    // value in every state until the next accept. The response fields are
    // cleared on accept (writes and errors return 0) and the read data is
    // captured at the end of READ_WAIT, when mem_rdata reflects the address
    // presented during READ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                rsp_rdata <= 16'h0000;
                rsp_err   <= addr_oor;
            end else if (state == READ_WAIT) begin
                rsp_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl with a behavioural registered-read memory.
// Expected responses are computed from a shadow copy of memory contents and
// queued when a request is driven, then popped and compared when rsp_valid
// appears.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata = 16'h0000;

    logic [15:0] mem    [0:DEPTH-1] = '{default: 16'h0000};
    logic [15:0] shadow [0:DEPTH-1] = '{default: 16'h0000};

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          lat;
        int          we_cnt;
    } exp_t;

    exp_t exp_q[$];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    mem_access_ctrl #(.MEM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read memory; out-of-range addresses read as 0 and never write.
    always @(posedge clk) begin
        if (mem_addr < 16'(DEPTH)) begin
            if (mem_we) mem[mem_addr[13:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[13:0]];
        end else begin
            mem_rdata <= 16'h0000;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one request, then measure latency and write activity until the
    // response, compare against the queued expectation, hold rsp_ready low for
    // 'hold' cycles and finish the handshake. After the accept edge the request
    // inputs are switched to the nxt_* values to show they are not re-sampled.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input int hold, input logic nxt_valid, input logic nxt_wr,
                           input logic [15:0] nxt_addr, input logic [15:0] nxt_wdata,
                           input string name);
        exp_t        e;
        int          lat;
        int          we_cnt;
        int          guard;
        logic [15:0] we_addr;
        logic [15:0] we_data;
        logic        oor;

        oor      = (addr >= 16'(DEPTH));
        e.err    = oor;
        e.lat    = oor ? 1 : (wr ? 2 : 3);
        e.we_cnt = (!oor && wr) ? 1 : 0;
        e.rdata  = (oor || wr) ? 16'h0000 : shadow[addr[13:0]];
        if (!oor && wr) shadow[addr[13:0]] = wdata;
        exp_q.push_back(e);

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, "/req_ready_idle"}, 32'(req_ready), 32'd1);

        @(posedge clk); #1;
        req_valid = nxt_valid;
        req_write = nxt_wr;
        req_addr  = nxt_addr;
        req_wdata = nxt_wdata;

        lat = 1;
        we_cnt = 0;
        we_addr = 16'h0000;
        we_data = 16'h0000;
        while (!rsp_valid && lat < 20) begin
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            @(posedge clk); #1;
            lat++;
        end

        e = exp_q.pop_front();
        check({name, "/latency"}, lat, e.lat);
        check({name, "/we_cycles"}, we_cnt, e.we_cnt);
        if (e.we_cnt != 0) begin
            check({name, "/we_addr"}, 32'(we_addr), 32'(addr));
            check({name, "/we_data"}, 32'(we_data), 32'(wdata));
        end
        check({name, "/rsp_err"}, 32'(rsp_err), 32'(e.err));
        check({name, "/rsp_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
        check({name, "/we_in_resp"}, 32'(mem_we), 32'd0);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, "/hold_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
            check({name, "/hold_err"}, 32'(rsp_err), 32'(e.err));
            check({name, "/hold_req_ready"}, 32'(req_ready), 32'd0);
            check({name, "/hold_we"}, 32'(mem_we), 32'd0);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({name, "/done_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "/done_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] rnd;

        // Reset values while reset is held, before any clock edge.
        #3;
        check("rst/req_ready", 32'(req_ready), 32'd1);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        check("rst/mem_we", 32'(mem_we), 32'd0);
        check("rst/mem_addr", 32'(mem_addr), 32'd0);
        check("rst/mem_wdata", 32'(mem_wdata), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic write then read-back; inputs scrambled after accept.
        run_txn(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, 1'b0, 16'hAAAA, 16'h5555, "wr10");
        run_txn(1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b1, 16'h0011, 16'h1111, "rd10");

        // Out-of-range read and write; 0xFFFF must not alias address 0.
        run_txn(1'b0, 16'h4000, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "rd4000");
        run_txn(1'b1, 16'h0000, 16'h5A5A, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "wr0");
        run_txn(1'b1, 16'hFFFF, 16'h1111, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "wrFFFF");
        run_txn(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "rd0");

        // Response held for 5 cycles by rsp_ready=0.
        run_txn(1'b0, 16'h0010, 16'h0000, 5, 1'b0, 1'b0, 16'h0000, 16'h0000, "rd10_hold");

        // Back-to-back writes with req_valid held high throughout.
        run_txn(1'b1, 16'h0001, 16'h0101, 2, 1'b1, 1'b1, 16'h0002, 16'h0202, "b2b_1");
        run_txn(1'b1, 16'h0002, 16'h0202, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "b2b_2");
        run_txn(1'b0, 16'h0001, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "rd1");
        run_txn(1'b0, 16'h0002, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "rd2");
        check("mem1_content", 32'(mem[1]), 32'h0101);
        check("mem2_content", 32'(mem[2]), 32'h0202);

        // Varied data patterns at consecutive addresses, including top of range.
        for (int i = 0; i < 4; i++) begin
            rnd = 16'($urandom);
            run_txn(1'b1, 16'h0100 + 16'(i), rnd, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "rnd_wr");
        end
        run_txn(1'b1, 16'h3FFF, 16'hC3C3, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "wr3FFF");
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, 16'h0100 + 16'(i), 16'h0000, 1, 1'b0, 1'b0, 16'h0000, 16'h0000, "rnd_rd");
        end
        run_txn(1'b0, 16'h3FFF, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "rd3FFF");

        // Reset pulse in the middle of a WRITE cycle.
        run_txn(1'b1, 16'h0020, 16'h1234, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "wr20");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hDEAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstw/we_before", 32'(mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstw/we_dropped", 32'(mem_we), 32'd0);
        check("rstw/req_ready", 32'(req_ready), 32'd1);
        check("rstw/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw/mem_addr", 32'(mem_addr), 32'd0);
        check("rstw/mem_wdata", 32'(mem_wdata), 32'd0);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rstw/no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("rstw/mem20_content", 32'(mem[16'h0020]), 32'h1234);
        run_txn(1'b0, 16'h0020, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "rd20");

        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
